// File: rtl/mat_row_bank.sv
// rtl/mat_row_bank.sv - SIZE x SIZE complex matrix bank with row/column reads and RR-arbitrated clients (option: MAT_ROW_BANK_CONJ_EN)
module mat_row_bank #(
  parameter int SIZE        = 4,
  parameter int WIDTH       = 64,
  parameter int NUM_CLIENTS = 2,
  localparam int AW = $clog2(SIZE),
  localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NUM_CLIENTS-1:0]                        rd_valid_i,
  input  logic [NUM_CLIENTS-1:0][AW-1:0]                rd_addr_i,
  input  logic [NUM_CLIENTS-1:0]                        rd_col_i,
  input  logic [NUM_CLIENTS-1:0]                        rd_conj_i,
  output logic [NUM_CLIENTS-1:0]                        rd_ready_o,
  output logic [SIZE-1:0][2*WIDTH-1:0]                  rd_data_o,
  output logic [AW-1:0]                                 rd_data_addr_o,
  output logic [CW-1:0]                                 rd_data_client_o,
  output logic                                          rd_data_valid_o,
  input  logic [NUM_CLIENTS-1:0]                        wr_valid_i,
  input  logic [NUM_CLIENTS-1:0][AW-1:0]                wr_addr_i,
  input  logic [NUM_CLIENTS-1:0][SIZE-1:0][2*WIDTH-1:0] wr_data_i,
  output logic [NUM_CLIENTS-1:0]                        wr_ready_o,
  input  logic                                          clear_i,
  output logic                                          err_o,
  output logic                                          busy_o
);

  localparam int EW = 2 * WIDTH;
  // Widened so the range check never compares against an unrepresentable constant.
  localparam logic [AW:0] SIZE_V = (AW + 1)'(SIZE);

  logic [SIZE-1:0][SIZE-1:0][EW-1:0] mem_q, mem_d;

  logic [CW-1:0] rd_rr_q, rd_rr_d;
  logic [CW-1:0] wr_rr_q, wr_rr_d;
  logic          rd_any, wr_any;
  logic [CW-1:0] rd_idx, wr_idx;

  logic [AW-1:0]         rd_addr_sel, wr_addr_sel;
  logic                  rd_col_sel;
  logic [SIZE-1:0][EW-1:0] wr_data_sel;
  logic                  rd_oob, wr_oob;
  logic [EW-1:0]         conj_mask;
  logic [SIZE-1:0][EW-1:0] rd_data_d;

  logic [SIZE-1:0][EW-1:0] rd_data_q;
  logic [AW-1:0]         rd_addr_q;
  logic [CW-1:0]         rd_client_q;
  logic                  rd_valid_q;
  logic                  err_q, err_d;

  generate
    if (NUM_CLIENTS == 1) begin : g_single
      // A lone client is always granted; no pointer is needed.
      assign rd_ready_o = 1'b1;
      assign wr_ready_o = 1'b1;
      assign rd_any     = rd_valid_i[0];
      assign wr_any     = wr_valid_i[0];
      assign rd_idx     = '0;
      assign wr_idx     = '0;
      assign rd_rr_d    = '0;
      assign wr_rr_d    = '0;
      logic unused_rr;
      assign unused_rr = ^{rd_rr_q, wr_rr_q};
    end else begin : g_multi
      logic [CW-1:0] rd_c, wr_c;

      // Read round-robin: scan from the pointer, first requester wins, pointer moves past it.
      always_comb begin
        rd_any     = 1'b0;
        rd_idx     = '0;
        rd_c       = '0;
        rd_ready_o = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
          rd_c = CW'((int'(rd_rr_q) + k) % NUM_CLIENTS);
          if (rd_valid_i[rd_c]) begin
            rd_any = 1'b1;
            rd_idx = rd_c;
          end
        end
        if (rd_any) rd_ready_o[rd_idx] = 1'b1;
        rd_rr_d = rd_any ? CW'((int'(rd_idx) + 1) % NUM_CLIENTS) : rd_rr_q;
      end

      // Write round-robin, independent pointer from the read side.
      always_comb begin
        wr_any     = 1'b0;
        wr_idx     = '0;
        wr_c       = '0;
        wr_ready_o = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
          wr_c = CW'((int'(wr_rr_q) + k) % NUM_CLIENTS);
          if (wr_valid_i[wr_c]) begin
            wr_any = 1'b1;
            wr_idx = wr_c;
          end
        end
        if (wr_any) wr_ready_o[wr_idx] = 1'b1;
        wr_rr_d = wr_any ? CW'((int'(wr_idx) + 1) % NUM_CLIENTS) : wr_rr_q;
      end
    end
  endgenerate

  assign rd_addr_sel = rd_addr_i[rd_idx];
  assign rd_col_sel  = rd_col_i[rd_idx];
  assign wr_addr_sel = wr_addr_i[wr_idx];
  assign wr_data_sel = wr_data_i[wr_idx];
  assign rd_oob      = ({1'b0, rd_addr_sel} >= SIZE_V);
  assign wr_oob      = ({1'b0, wr_addr_sel} >= SIZE_V);

`ifdef MAT_ROW_BANK_CONJ_EN
  // Conjugation flips only the sign bit of the imag half of each element.
  assign conj_mask = {rd_conj_i[rd_idx], {(EW - 1){1'b0}}};
`else
  assign conj_mask = '0;
  logic unused_conj;
  assign unused_conj = ^rd_conj_i;
`endif

  generate
    for (genvar j = 0; j < SIZE; j++) begin : g_elem
      logic [EW-1:0] raw;
      // Row mode picks element j of the addressed row; column mode picks the addressed element of row j.
      assign raw          = rd_col_sel ? mem_q[j][rd_addr_sel] : mem_q[rd_addr_sel][j];
      assign rd_data_d[j] = rd_oob ? '0 : (raw ^ conj_mask);
    end
  endgenerate

  // Next array state: clear beats a same-cycle write; out-of-range writes are dropped.
  always_comb begin
    mem_d = mem_q;
    if (clear_i) begin
      mem_d = '0;
    end else if (wr_any && !wr_oob) begin
      mem_d[wr_addr_sel] = wr_data_sel;
    end
  end

  assign err_d = err_q | (rd_any & rd_oob) | (wr_any & wr_oob);

  // Array storage; reads above see mem_q so a same-edge write or clear is not visible to them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Arbitration pointers and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_rr_q <= '0;
      wr_rr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rd_rr_q <= rd_rr_d;
      wr_rr_q <= wr_rr_d;
      err_q   <= err_d;
    end
  end

  // One-cycle read return; payload holds its last value when no grant occurs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_addr_q   <= '0;
      rd_client_q <= '0;
    end else begin
      rd_valid_q <= rd_any;
      if (rd_any) begin
        rd_data_q   <= rd_data_d;
        rd_addr_q   <= rd_addr_sel;
        rd_client_q <= rd_idx;
      end
    end
  end

  assign rd_data_o        = rd_data_q;
  assign rd_data_addr_o   = rd_addr_q;
  assign rd_data_client_o = rd_client_q;
  assign rd_data_valid_o  = rd_valid_q;
  assign err_o            = err_q;
  assign busy_o           = (|rd_valid_i) | (|wr_valid_i) | rd_valid_q;

endmodule

// File: tb/tb_mat_row_bank.sv
// tb/tb_mat_row_bank.sv - directed self-checking bench for mat_row_bank
module tb_mat_row_bank;
  localparam int S  = 4;
  localparam int W  = 64;
  localparam int N  = 2;
  localparam int AW = 2;
  localparam int CW = 1;
`ifdef MAT_ROW_BANK_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif
  localparam logic [63:0] SIGN = 64'h8000_0000_0000_0000;

  typedef logic [S-1:0][2*W-1:0] row_t;

  logic clk, rst_n;
  logic [N-1:0] rd_valid, rd_col, rd_conj, rd_ready, wr_valid, wr_ready;
  logic [N-1:0][AW-1:0] rd_addr, wr_addr;
  logic [N-1:0][S-1:0][2*W-1:0] wr_data;
  row_t rd_data;
  logic [AW-1:0] rd_data_addr;
  logic [CW-1:0] rd_data_client;
  logic rd_data_valid, clear, err, busy;

  logic [0:0] s_rd_valid, s_rd_col, s_rd_conj, s_rd_ready, s_wr_valid, s_wr_ready;
  logic [0:0][1:0] s_rd_addr, s_wr_addr;
  logic [0:0][2:0][15:0] s_wr_data;
  logic [2:0][15:0] s_rd_data;
  logic [1:0] s_rd_data_addr;
  logic [0:0] s_rd_data_client;
  logic s_rd_data_valid, s_clear, s_err, s_busy;

  int checks = 0;
  int errors = 0;
  row_t mdl [S];
  row_t exp_row;

  mat_row_bank #(.SIZE(S), .WIDTH(W), .NUM_CLIENTS(N)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_col_i(rd_col), .rd_conj_i(rd_conj),
    .rd_ready_o(rd_ready), .rd_data_o(rd_data), .rd_data_addr_o(rd_data_addr),
    .rd_data_client_o(rd_data_client), .rd_data_valid_o(rd_data_valid),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .clear_i(clear), .err_o(err), .busy_o(busy)
  );

  mat_row_bank #(.SIZE(3), .WIDTH(8), .NUM_CLIENTS(1)) u_dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_valid_i(s_rd_valid), .rd_addr_i(s_rd_addr), .rd_col_i(s_rd_col), .rd_conj_i(s_rd_conj),
    .rd_ready_o(s_rd_ready), .rd_data_o(s_rd_data), .rd_data_addr_o(s_rd_data_addr),
    .rd_data_client_o(s_rd_data_client), .rd_data_valid_o(s_rd_data_valid),
    .wr_valid_i(s_wr_valid), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data), .wr_ready_o(s_wr_ready),
    .clear_i(s_clear), .err_o(s_err), .busy_o(s_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [2*W-1:0] elem(input real re, input real im);
    return {$realtobits(im), $realtobits(re)};
  endfunction

  function automatic row_t row_pat(input int i, input real im);
    row_t r;
    for (int j = 0; j < S; j++) r[j] = elem($itor(i * 4 + j), im);
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step;
    step;
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_data_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rd_data); end
    checks++; if (rd_data_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rd_data_addr); end
    checks++; if (rd_data_client !== '0) begin errors++; $display("FAIL reset_client: got %0d expected 0", rd_data_client); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_oob_single;
    checks++; if (s_rd_ready !== 1'b1 || s_wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got rd=%b wr=%b expected 1 1", s_rd_ready, s_wr_ready); end
    s_wr_valid = 1'b1; s_wr_addr[0] = 2'd2; s_wr_data[0] = {16'h0c0c, 16'h0b0b, 16'h0a0a};
    step;
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL oob_err_inrange: got %b expected 0", s_err); end
    s_wr_addr[0] = 2'd3; s_wr_data[0] = {16'hffff, 16'hffff, 16'hffff};
    step;
    s_wr_valid = 1'b0;
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL oob_err_write: got %b expected 1", s_err); end
    s_rd_valid = 1'b1; s_rd_addr[0] = 2'd2; s_rd_col = 1'b0;
    step;
    checks++; if (s_rd_data !== {16'h0c0c, 16'h0b0b, 16'h0a0a}) begin errors++; $display("FAIL oob_row2: got %h expected 0c0c0b0b0a0a", s_rd_data); end
    s_rd_addr[0] = 2'd3;
    step;
    checks++; if (s_rd_data !== '0 || s_rd_data_valid !== 1'b1 || s_rd_data_addr !== 2'd3 || s_rd_data_client !== 1'b0) begin
      errors++; $display("FAIL oob_read: got data=%h v=%b a=%0d c=%0d expected 0 1 3 0", s_rd_data, s_rd_data_valid, s_rd_data_addr, s_rd_data_client); end
    s_rd_addr[0] = 2'd0; s_rd_col = 1'b1;
    step;
    checks++; if (s_rd_data !== {16'h0a0a, 16'h0000, 16'h0000}) begin errors++; $display("FAIL single_col0: got %h expected 0a0a00000000", s_rd_data); end
    s_rd_valid = 1'b0; s_rd_col = 1'b0;
    step;
  endtask

  task automatic test_row_read;
    for (int i = 0; i < S; i++) begin
      mdl[i] = row_pat(i, 0.0);
      wr_valid = 2'b01; wr_addr[0] = AW'(i); wr_data[0] = mdl[i];
      #1;
      checks++; if (wr_ready !== 2'b01) begin errors++; $display("FAIL wr_grant_row%0d: got %b expected 01", i, wr_ready); end
      step;
    end
    wr_valid = '0;
    rd_valid = 2'b10; rd_addr[1] = 2'd2; rd_col = '0; rd_conj = '0;
    #1;
    checks++; if (rd_ready !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL row_grant: got ready=%b busy=%b expected 10 1", rd_ready, busy); end
    step;
    for (int j = 0; j < S; j++) exp_row[j] = {64'h0, $realtobits($itor(8 + j))};
    checks++; if (rd_data_valid !== 1'b1 || rd_data_addr !== 2'd2 || rd_data_client !== 1'b1) begin
      errors++; $display("FAIL row_ret_ctl: got v=%b a=%0d c=%0d expected 1 2 1", rd_data_valid, rd_data_addr, rd_data_client); end
    checks++; if (rd_data !== exp_row) begin errors++; $display("FAIL row_ret_data: got %h expected %h", rd_data, exp_row); end
    rd_valid = '0;
    step;
    checks++; if (rd_data_valid !== 1'b0 || rd_data !== exp_row) begin errors++; $display("FAIL row_hold: got v=%b data=%h expected 0 %h", rd_data_valid, rd_data, exp_row); end
  endtask

  task automatic test_col_read;
    rd_valid = 2'b10; rd_addr[1] = 2'd1; rd_col = 2'b10; rd_conj = 2'b10;
    step;
    rd_valid = '0;
    for (int j = 0; j < S; j++) exp_row[j] = {(CONJ ? SIGN : 64'h0), $realtobits($itor(j * 4 + 1))};
    checks++; if (rd_data !== exp_row || rd_data_addr !== 2'd1) begin errors++; $display("FAIL col_read: got %h a=%0d expected %h a=1", rd_data, rd_data_addr, exp_row); end
    for (int i = 0; i < S; i++) begin
      mdl[i] = row_pat(i, 2.0);
      wr_valid = 2'b01; wr_addr[0] = AW'(i); wr_data[0] = mdl[i];
      step;
    end
    wr_valid = '0;
    rd_valid = 2'b10;
    step;
    rd_valid = '0; rd_col = '0; rd_conj = '0;
    for (int j = 0; j < S; j++) exp_row[j] = elem($itor(j * 4 + 1), CONJ ? -2.0 : 2.0);
    checks++; if (rd_data !== exp_row) begin errors++; $display("FAIL col_conj: got %h expected %h", rd_data, exp_row); end
    step;
  endtask

  task automatic test_round_robin;
    rd_valid = 2'b11; rd_addr[0] = 2'd0; rd_addr[1] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (rd_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, rd_ready, (k % 2) ? 2'b10 : 2'b01); end
      step;
      checks++; if (rd_data_valid !== 1'b1 || rd_data_client !== CW'(k % 2) || rd_data_addr !== AW'(k % 2) || rd_data !== mdl[k % 2]) begin
        errors++; $display("FAIL rr_return%0d: got v=%b c=%0d a=%0d expected 1 %0d %0d", k, rd_data_valid, rd_data_client, rd_data_addr, k % 2, k % 2); end
    end
    rd_valid = '0;
    step;
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", rd_data_valid); end
  endtask

  task automatic test_read_before_write;
    row_t sevens;
    for (int j = 0; j < S; j++) sevens[j] = elem(7.0, 7.0);
    wr_valid = 2'b01; wr_addr[0] = 2'd3; wr_data[0] = sevens;
    rd_valid = 2'b01; rd_addr[0] = 2'd3;
    #1;
    checks++; if (rd_ready !== 2'b01 || wr_ready !== 2'b01) begin errors++; $display("FAIL rbw_grant: got rd=%b wr=%b expected 01 01", rd_ready, wr_ready); end
    step;
    wr_valid = '0;
    checks++; if (rd_data !== mdl[3]) begin errors++; $display("FAIL rbw_old: got %h expected %h", rd_data, mdl[3]); end
    mdl[3] = sevens;
    step;
    rd_valid = '0;
    checks++; if (rd_data !== sevens || rd_data_valid !== 1'b1) begin errors++; $display("FAIL rbw_new: got v=%b %h expected 1 %h", rd_data_valid, rd_data, sevens); end
    step;
  endtask

  task automatic test_clear;
    clear = 1'b1;
    wr_valid = 2'b10; wr_addr[1] = 2'd0; wr_data[1] = row_pat(25, 99.0);
    rd_valid = 2'b10; rd_addr[1] = 2'd0;
    #1;
    checks++; if (wr_ready !== 2'b10) begin errors++; $display("FAIL clear_wr_grant: got %b expected 10", wr_ready); end
    step;
    clear = 1'b0; wr_valid = '0;
    checks++; if (rd_data !== mdl[0]) begin errors++; $display("FAIL clear_preread: got %h expected %h", rd_data, mdl[0]); end
    for (int i = 0; i < S; i++) begin
      mdl[i] = '0;
      rd_addr[1] = AW'(i);
      step;
      checks++; if (rd_data !== '0 || rd_data_addr !== AW'(i)) begin errors++; $display("FAIL clear_row%0d: got a=%0d %h expected 0", i, rd_data_addr, rd_data); end
    end
    rd_valid = '0;
    step;
  endtask

  task automatic test_reset_cancel;
    mdl[1] = row_pat(5, 6.0);
    wr_valid = 2'b01; wr_addr[0] = 2'd1; wr_data[0] = mdl[1];
    step;
    wr_valid = '0;
    rd_valid = 2'b10; rd_addr[1] = 2'd1;
    step;
    checks++; if (rd_data_valid !== 1'b1 || rd_data !== mdl[1] || rd_data_client !== 1'b1) begin errors++; $display("FAIL pre_reset_read: got v=%b %h expected 1 %h", rd_data_valid, rd_data, mdl[1]); end
    rst_n = 1'b0;
    rd_valid = 2'b01; rd_addr[0] = 2'd1;
    wr_valid = 2'b01; wr_addr[0] = 2'd2; wr_data[0] = row_pat(3, 3.0);
    step;
    rd_valid = '0; wr_valid = '0;
    checks++; if (rd_data_valid !== 1'b0 || rd_data !== '0 || rd_data_addr !== '0 || rd_data_client !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_cancel: got v=%b a=%0d c=%0d e=%b data=%h expected all zero", rd_data_valid, rd_data_addr, rd_data_client, err, rd_data); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err_single: got %b expected 0", s_err); end
    rst_n = 1'b1;
    for (int i = 0; i < S; i++) mdl[i] = '0;
    rd_valid = 2'b11; rd_addr[0] = 2'd2; rd_addr[1] = 2'd3;
    #1;
    checks++; if (rd_ready !== 2'b01) begin errors++; $display("FAIL reset_rr_ptr: got %b expected 01", rd_ready); end
    step;
    checks++; if (rd_data !== '0 || rd_data_client !== 1'b0) begin errors++; $display("FAIL reset_row2: got c=%0d %h expected 0 0", rd_data_client, rd_data); end
    step;
    checks++; if (rd_data !== '0 || rd_data_client !== 1'b1) begin errors++; $display("FAIL reset_row3: got c=%0d %h expected 1 0", rd_data_client, rd_data); end
    rd_valid = 2'b01;
    for (int i = 0; i < 2; i++) begin
      rd_addr[0] = AW'(i);
      step;
      checks++; if (rd_data !== '0 || rd_data_valid !== 1'b1) begin errors++; $display("FAIL reset_row%0d: got v=%b %h expected 1 0", i, rd_data_valid, rd_data); end
    end
    rd_valid = '0;
    step;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL final_err: got %b expected 0", err); end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    rd_valid = '0; rd_addr = '0; rd_col = '0; rd_conj = '0;
    wr_valid = '0; wr_addr = '0; wr_data = '0;
    s_rd_valid = '0; s_rd_addr = '0; s_rd_col = '0; s_rd_conj = '0;
    s_wr_valid = '0; s_wr_addr = '0; s_wr_data = '0; s_clear = 1'b0;
    test_reset;
    test_oob_single;
    test_row_read;
    test_col_read;
    test_round_robin;
    test_read_before_write;
    test_clear;
    test_reset_cancel;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
